// File: rtl/branch_pkg.sv
// Shared types and constants for EX-stage branch resolution.
package branch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    typedef enum logic {
        BC_IDLE  = 1'b0,
        BC_FLUSH = 1'b1
    } bc_state_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       tk
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (tk && ctr != CTR_ST) begin
            nxt = ctr + 2'd1;
        end else if (!tk && ctr != CTR_SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters.
// One combinational read port for fetch, one update port for EX.
module branch_bht
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rd_pc_i,
    output logic        rd_tk_o,
    input  logic        upd_en_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_tk_i
);

    localparam int IW = $clog2(ENTRIES);

    logic [1:0]    ctr_q [ENTRIES];
    logic [1:0]    ctr_d [ENTRIES];
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] upd_idx;
    logic          unused_pc;

    assign rd_idx  = rd_pc_i[IW+1:2];
    assign upd_idx = upd_pc_i[IW+1:2];
    assign rd_tk_o = ctr_q[rd_idx][1];

    assign unused_pc = ^{rd_pc_i[31:IW+2], rd_pc_i[1:0],
                         upd_pc_i[31:IW+2], upd_pc_i[1:0]};

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ctr_d[i] = ctr_q[i];
        end
        if (upd_en_i) begin
            ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_tk_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution, PC redirect and IF/ID flush sequencing.
// Define BRANCH_BHT_EN to add the 2-bit BHT predictor path.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_ENTRIES  = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        ex_valid_i,
    input  logic        ex_stall_i,
    input  logic        ex_is_br_i,
    input  logic        ex_is_jal_i,
    input  logic        ex_is_jalr_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_tk_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsigned_o,
    input  logic [31:0] if_pc_i,
    output logic        if_pred_tk_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    bc_state_e   state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    logic        is_jal;
    logic        is_jalr;
    logic        is_br;
    logic        br_cond;
    logic        taken;
    logic        resolve;
    logic        need_redir;
    logic [31:0] redir_pc;

    assign br_unsigned_o = (ex_funct3_i == F3_BLTU) ||
                           (ex_funct3_i == F3_BGEU);

    // JAL wins over JALR, which wins over a conditional branch.
    assign is_jal  = ex_is_jal_i;
    assign is_jalr = ex_is_jalr_i & ~ex_is_jal_i;
    assign is_br   = ex_is_br_i & ~ex_is_jal_i & ~ex_is_jalr_i;

    always_comb begin
        br_cond = 1'b0;
        case (ex_funct3_i)
            F3_BEQ:  br_cond = br_equal_i;
            F3_BNE:  br_cond = ~br_equal_i;
            F3_BLT:  br_cond = br_less_i;
            F3_BGE:  br_cond = ~br_less_i;
            F3_BLTU: br_cond = br_less_i;
            F3_BGEU: br_cond = ~br_less_i;
            default: br_cond = 1'b0;
        endcase
    end

    assign taken   = is_jal | is_jalr | (is_br & br_cond);
    assign resolve = ex_valid_i & ~ex_stall_i &
                     (is_jal | is_jalr | is_br) &
                     (state_q == BC_IDLE);
    assign redir_pc = taken ? ex_target_i : ex_pc_i + 32'd4;

`ifdef BRANCH_BHT_EN
    assign need_redir = is_jal | is_jalr | (taken != ex_pred_tk_i);

    branch_bht #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (i_clk),
        .reset    (i_reset),
        .rd_pc_i  (if_pc_i),
        .rd_tk_o  (if_pred_tk_o),
        .upd_en_i (resolve & is_br),
        .upd_pc_i (ex_pc_i),
        .upd_tk_i (br_cond)
    );
`else
    logic unused_pred;

    assign need_redir   = taken;
    assign if_pred_tk_o = 1'b0;
    assign unused_pred  = ^{if_pc_i, ex_pred_tk_i};
`endif

    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;
        unique case (state_q)
            BC_IDLE: begin
                if (resolve) begin
                    br_cnt_d = sat_inc(br_cnt_q);
                    if (need_redir) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = redir_pc;
                        mis_cnt_d     = sat_inc(mis_cnt_q);
                        state_d       = BC_FLUSH;
                        fcnt_d        = FLUSH_LOAD;
                    end
                end
            end
            BC_FLUSH: begin
                // EX holds wrong-path work here; stalls do not hold the count.
                if (fcnt_q == '0) begin
                    state_d = BC_IDLE;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: state_d = BC_IDLE;
        endcase
        flush_d = (state_d == BC_FLUSH);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= BC_IDLE;
            fcnt_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            flush_q       <= flush_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign flush_o       = flush_q;
    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mis_cnt_q;

endmodule
